multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: OPW, 4, opcode width in bits.
REQ-002 Parameter: CNTW, 16, width of the retired-instruction counter.
REQ-003 Port: CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: R  input  1  reset; synchronous, active-high.
REQ-005 Port: OPCODE  input  OPW  opcode field from the instruction register; valid from DECODE onward.
REQ-006 Port: MEM_READY  input  1  memory completes the pending access this cycle.
REQ-007 Port: ZERO  input  1  ALU zero flag, sampled in EXEC.
REQ-008 Port: MEM_REQ / MEM_WE  output  1 each  memory access request / write qualifier.
REQ-009 Port: IR_WE / PC_WE / RF_WE  output  1 each  instruction-register, PC and register-file write strobes.
REQ-010 Port: PC_SRC  output  2  PC source: 0 = PC+1, 1 = branch target, 2 = jump target.
REQ-011 Port: RF_SRC  output  1  register-file write data: 0 = ALU, 1 = memory.
REQ-012 Port: ALU_OP  output  3  ALU operation: 0 ADD, 1 SUB, 2 AND, 3 OR.
REQ-013 Port: STATE  output  3  current state encoding.
REQ-014 Port: HALTED  output  1  high while in HALT.
REQ-015 Port: RETIRED  output  CNTW  count of completed instructions.

Function
REQ-016 States and encodings SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to FETCH on the next edge.
REQ-017 Opcodes SHALL be ADD=0, SUB=1, AND=2, OR=3, LD=4, ST=5, BEQ=6, JMP=7, HLT=15; any other opcode is illegal and SHALL be treated as a NOP.
REQ-018 FETCH: MEM_REQ=1 and MEM_WE=0; the block SHALL stay in FETCH while MEM_READY=0.
REQ-019 FETCH exit: when MEM_READY=1, IR_WE=1, PC_WE=1 and PC_SRC=0 SHALL assert in that same cycle (Mealy), and the next state is DECODE.
REQ-020 DECODE, ALU ops, LD, ST and BEQ: next state is EXEC.
REQ-021 DECODE, JMP: PC_WE=1 and PC_SRC=2; next state is FETCH; RETIRED increments.
REQ-022 DECODE, HLT: next state is HALT; RETIRED increments.
REQ-023 DECODE, illegal opcode: next state is FETCH; RETIRED increments.
REQ-024 EXEC, ALU ops: ALU_OP = OPCODE[1:0]; next state is WB.
REQ-025 EXEC, LD/ST: ALU_OP=ADD (address computation); next state is MEM.
REQ-026 EXEC, BEQ: ALU_OP=SUB; if ZERO=1, PC_WE=1 and PC_SRC=1; next state is FETCH; RETIRED increments.
REQ-027 MEM: MEM_REQ=1 and MEM_WE=(OPCODE==ST); the block SHALL hold in MEM while MEM_READY=0.
REQ-028 MEM exit: on MEM_READY=1, LD goes to WB; ST goes to FETCH and RETIRED increments.
REQ-029 WB: RF_WE=1, RF_SRC=(OPCODE==LD); next state is FETCH; RETIRED increments.
REQ-030 HALT: all strobes 0, HALTED=1; the block SHALL remain in HALT until R.
REQ-031 Outputs not listed for a state SHALL be 0, and at most one of IR_WE, RF_WE or MEM_WE SHALL be high in any cycle.
REQ-032 RETIRED SHALL increment by exactly 1 per completed instruction and wrap from 2^CNTW-1 to 0.

Reset
REQ-033 While R=1, all outputs SHALL be 0 in that cycle, overriding any Mealy term.
REQ-034 The edge with R=1 SHALL load state FETCH and RETIRED=0, including mid-access in MEM; a pending MEM_READY SHALL be ignored.
REQ-035 The first cycle after R falls SHALL present MEM_REQ=1 in FETCH.

Structure
REQ-036 Shared package ctrl_pkg SHALL hold the state encodings, opcode constants, ALU_OP codes and PC_SRC codes.
REQ-037 Sub-module retire_counter (CNTW-bit, synchronous reset, increment enable, wrapping) SHALL implement RETIRED; the rest is one FSM in this module.

Verification
REQ-038 ADD with MEM_READY tied 1 -> STATE sequence 0,1,2,4,0; RF_WE=1 only in WB; RETIRED 0->1.
REQ-039 LD with 3 wait cycles in FETCH and 2 in MEM -> MEM_REQ held 4 cycles, then 3 cycles; IR_WE pulses once; WB with RF_SRC=1.
REQ-040 ST -> MEM_WE=1 only in the MEM cycle with MEM_READY=1; no RF_WE; returns to FETCH; RETIRED+1.
REQ-041 BEQ with ZERO=1 -> PC_WE=1, PC_SRC=1 in EXEC; BEQ with ZERO=0 -> PC_WE=0; JMP -> PC_SRC=2 in DECODE.
REQ-042 HLT -> HALTED=1 held for 10 cycles, then R=1 for 1 cycle -> STATE=0, RETIRED=0.
REQ-043 Preload RETIRED to 16'hFFFF via 65535 opcode-8 NOPs, then one more -> RETIRED=0; R asserted in MEM -> next STATE=0, all strobes 0 during R.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// ALU operation codes and PC source selects.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_LD  = 4'd4;
  localparam logic [3:0] OP_ST  = 4'd5;
  localparam logic [3:0] OP_BEQ = 4'd6;
  localparam logic [3:0] OP_JMP = 4'd7;
  localparam logic [3:0] OP_HLT = 4'd15;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  localparam logic [1:0] PCS_INC    = 2'd0;
  localparam logic [1:0] PCS_BRANCH = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;

  // Instruction classes: everything the FSM needs to know about an opcode.
  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LD,
    CLS_ST,
    CLS_BEQ,
    CLS_JMP,
    CLS_HLT,
    CLS_ILL
  } op_class_t;

endpackage

// File: rtl/retire_counter.sv
// Wrapping count of retired instructions with synchronous reset.
module retire_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (en)
      count <= count + W'(1);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: fetch/decode/exec/mem/wb sequencing with
// Mealy strobes on memory handshake, branch condition and retirement count.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            R,
  input  logic [OPW-1:0]  OPCODE,
  input  logic            MEM_READY,
  input  logic            ZERO,
  output logic            MEM_REQ,
  output logic            MEM_WE,
  output logic            IR_WE,
  output logic            PC_WE,
  output logic            RF_WE,
  output logic [1:0]      PC_SRC,
  output logic            RF_SRC,
  output logic [2:0]      ALU_OP,
  output logic [2:0]      STATE,
  output logic            HALTED,
  output logic [CNTW-1:0] RETIRED
);

  // Memory handshake: MEM_REQ holds the request; the access completes in the
  // cycle MEM_READY is high, and only then does the FSM leave FETCH or MEM.

  state_t          state;
  state_t          state_nx;
  op_class_t       cls;
  logic            mem_req, mem_we, ir_we, pc_we, rf_we, rf_src, halted;
  logic [1:0]      pc_src;
  logic [2:0]      alu_op;
  logic            retire;
  logic [CNTW-1:0] count;

  always_comb begin
    cls = CLS_ILL;
    case (OPCODE)
      OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_AND), OPW'(OP_OR): cls = CLS_ALU;
      OPW'(OP_LD):  cls = CLS_LD;
      OPW'(OP_ST):  cls = CLS_ST;
      OPW'(OP_BEQ): cls = CLS_BEQ;
      OPW'(OP_JMP): cls = CLS_JMP;
      OPW'(OP_HLT): cls = CLS_HLT;
      default:      cls = CLS_ILL;
    endcase
  end

  always_comb begin
    state_nx = state;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    rf_we    = 1'b0;
    rf_src   = 1'b0;
    pc_src   = PCS_INC;
    alu_op   = ALU_ADD;
    halted   = 1'b0;
    retire   = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (MEM_READY) begin
          ir_we    = 1'b1;
          pc_we    = 1'b1;
          state_nx = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (cls)
          CLS_JMP: begin
            pc_we    = 1'b1;
            pc_src   = PCS_JUMP;
            retire   = 1'b1;
            state_nx = ST_FETCH;
          end
          CLS_HLT: begin
            retire   = 1'b1;
            state_nx = ST_HALT;
          end
          CLS_ILL: begin
            retire   = 1'b1;
            state_nx = ST_FETCH;
          end
          default: state_nx = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (cls)
          CLS_ALU: begin
            alu_op   = {1'b0, OPCODE[1:0]};
            state_nx = ST_WB;
          end
          CLS_LD, CLS_ST: begin
            alu_op   = ALU_ADD;
            state_nx = ST_MEM;
          end
          CLS_BEQ: begin
            alu_op   = ALU_SUB;
            retire   = 1'b1;
            state_nx = ST_FETCH;
            if (ZERO) begin
              pc_we  = 1'b1;
              pc_src = PCS_BRANCH;
            end
          end
          default: state_nx = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls == CLS_ST);
        if (MEM_READY) begin
          if (cls == CLS_LD) begin
            state_nx = ST_WB;
          end else begin
            retire   = (cls == CLS_ST);
            state_nx = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        rf_we    = 1'b1;
        rf_src   = (cls == CLS_LD);
        retire   = 1'b1;
        state_nx = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      default: state_nx = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (R)
      state <= ST_FETCH;
    else
      state <= state_nx;
  end

  retire_counter #(.W(CNTW)) u_retire (
    .clk   (CLK),
    .rst   (R),
    .en    (retire),
    .count (count)
  );

  // Reset forces every output low in the same cycle, overriding Mealy terms.
  assign MEM_REQ = mem_req & ~R;
  assign MEM_WE  = mem_we  & ~R;
  assign IR_WE   = ir_we   & ~R;
  assign PC_WE   = pc_we   & ~R;
  assign RF_WE   = rf_we   & ~R;
  assign RF_SRC  = rf_src  & ~R;
  assign HALTED  = halted  & ~R;
  assign PC_SRC  = R ? 2'd0 : pc_src;
  assign ALU_OP  = R ? 3'd0 : alu_op;
  assign STATE   = R ? 3'd0 : 3'(state);
  assign RETIRED = R ? '0 : count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl; a second, 8-bit-counter
// instance shares the stimulus so counter wrap is reachable in a short run.
module tb_multicycle_ctrl;

  logic        CLK = 1'b0;
  logic        R = 1'b1;
  logic [3:0]  OPCODE = 4'd0;
  logic        MEM_READY = 1'b0;
  logic        ZERO = 1'b0;

  logic        MEM_REQ, MEM_WE, IR_WE, PC_WE, RF_WE, RF_SRC, HALTED;
  logic [1:0]  PC_SRC;
  logic [2:0]  ALU_OP, STATE;
  logic [15:0] RETIRED;

  logic        mem_req_w, mem_we_w, ir_we_w, pc_we_w, rf_we_w, rf_src_w, halted_w;
  logic [1:0]  pc_src_w;
  logic [2:0]  alu_op_w, state_w;
  logic [7:0]  retired_w;

  int n_vec = 0;
  int n_bad = 0;

  // {STATE, MEM_REQ, MEM_WE, IR_WE, PC_WE, RF_WE, PC_SRC, RF_SRC, ALU_OP, HALTED}
  logic [14:0] obs, obs_w;
  assign obs   = {STATE, MEM_REQ, MEM_WE, IR_WE, PC_WE, RF_WE, PC_SRC, RF_SRC, ALU_OP, HALTED};
  assign obs_w = {state_w, mem_req_w, mem_we_w, ir_we_w, pc_we_w, rf_we_w, pc_src_w, rf_src_w,
                  alu_op_w, halted_w};

  multicycle_ctrl #(.OPW(4), .CNTW(16)) dut (
    .CLK(CLK), .R(R), .OPCODE(OPCODE), .MEM_READY(MEM_READY), .ZERO(ZERO),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .IR_WE(IR_WE), .PC_WE(PC_WE), .RF_WE(RF_WE),
    .PC_SRC(PC_SRC), .RF_SRC(RF_SRC), .ALU_OP(ALU_OP), .STATE(STATE), .HALTED(HALTED),
    .RETIRED(RETIRED)
  );

  multicycle_ctrl #(.OPW(4), .CNTW(8)) dut_w (
    .CLK(CLK), .R(R), .OPCODE(OPCODE), .MEM_READY(MEM_READY), .ZERO(ZERO),
    .MEM_REQ(mem_req_w), .MEM_WE(mem_we_w), .IR_WE(ir_we_w), .PC_WE(pc_we_w), .RF_WE(rf_we_w),
    .PC_SRC(pc_src_w), .RF_SRC(rf_src_w), .ALU_OP(alu_op_w), .STATE(state_w), .HALTED(halted_w),
    .RETIRED(retired_w)
  );

  // ---------------- clock / timeout ----------------
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1, "timeout");
  end

  // ---------------- vector helpers ----------------
  typedef struct packed {
    logic [3:0]  op;
    logic        rdy;
    logic        z;
    logic        r;
    logic [14:0] exp;
    logic [15:0] ret;
  } row_t;

  function automatic logic [14:0] pk(int st, int mreq, int mwe, int ir, int pc, int rf,
                                     int pcs, int rfs, int alu, int h);
    logic [14:0] v;
    v = {st[2:0], mreq[0], mwe[0], ir[0], pc[0], rf[0], pcs[1:0], rfs[0], alu[2:0], h[0]};
    return v;
  endfunction

  function automatic row_t mk(int op, int rdy, int z, int r, logic [14:0] e, int ret);
    row_t x;
    x.op  = op[3:0];
    x.rdy = rdy[0];
    x.z   = z[0];
    x.r   = r[0];
    x.exp = e;
    x.ret = ret[15:0];
    return x;
  endfunction

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic drive(input row_t t);
    @(posedge CLK);
    #1;
    OPCODE    = t.op;
    MEM_READY = t.rdy;
    ZERO      = t.z;
    R         = t.r;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    row_t t[$];
    t.push_back(mk(0, 1, 1, 1, pk(0,0,0,0,0,0,0,0,0,0), 0));
    t.push_back(mk(7, 1, 1, 1, pk(0,0,0,0,0,0,0,0,0,0), 0));
    t.push_back(mk(0, 0, 0, 0, pk(0,1,0,0,0,0,0,0,0,0), 0));
    foreach (t[k]) begin
      drive(t[k]);
      n_vec++;
      if (obs !== t[k].exp || RETIRED !== t[k].ret) begin
        n_bad++;
        $display("FAIL reset row%0d: outs=%h retired=%0d, want %h / %0d",
                 k, obs, RETIRED, t[k].exp, t[k].ret);
      end
    end
  endtask

  task automatic test_add();
    row_t t[$];
    t.push_back(mk(0, 1, 0, 1, pk(0,0,0,0,0,0,0,0,0,0), 0));
    t.push_back(mk(0, 1, 0, 0, pk(0,1,0,1,1,0,0,0,0,0), 0));
    t.push_back(mk(0, 1, 0, 0, pk(1,0,0,0,0,0,0,0,0,0), 0));
    t.push_back(mk(0, 1, 0, 0, pk(2,0,0,0,0,0,0,0,0,0), 0));
    t.push_back(mk(0, 1, 0, 0, pk(4,0,0,0,0,1,0,0,0,0), 0));
    t.push_back(mk(0, 1, 0, 0, pk(0,1,0,1,1,0,0,0,0,0), 1));
    foreach (t[k]) begin
      drive(t[k]);
      n_vec++;
      if (obs !== t[k].exp || RETIRED !== t[k].ret) begin
        n_bad++;
        $display("FAIL add row%0d: outs=%h retired=%0d, want %h / %0d",
                 k, obs, RETIRED, t[k].exp, t[k].ret);
      end
    end
  endtask

  task automatic test_ld_waits();
    row_t t[$];
    t.push_back(mk(4, 0, 0, 1, pk(0,0,0,0,0,0,0,0,0,0), 0));
    for (int i = 0; i < 3; i++)
      t.push_back(mk(4, 0, 0, 0, pk(0,1,0,0,0,0,0,0,0,0), 0));
    t.push_back(mk(4, 1, 0, 0, pk(0,1,0,1,1,0,0,0,0,0), 0));
    t.push_back(mk(4, 0, 0, 0, pk(1,0,0,0,0,0,0,0,0,0), 0));
    t.push_back(mk(4, 0, 0, 0, pk(2,0,0,0,0,0,0,0,0,0), 0));
    t.push_back(mk(4, 0, 0, 0, pk(3,1,0,0,0,0,0,0,0,0), 0));
    t.push_back(mk(4, 0, 0, 0, pk(3,1,0,0,0,0,0,0,0,0), 0));
    t.push_back(mk(4, 1, 0, 0, pk(3,1,0,0,0,0,0,0,0,0), 0));
    t.push_back(mk(4, 0, 0, 0, pk(4,0,0,0,0,1,0,1,0,0), 0));
    t.push_back(mk(4, 0, 0, 0, pk(0,1,0,0,0,0,0,0,0,0), 1));
    foreach (t[k]) begin
      drive(t[k]);
      n_vec++;
      if (obs !== t[k].exp || RETIRED !== t[k].ret) begin
        n_bad++;
        $display("FAIL ld_waits row%0d: outs=%h retired=%0d, want %h / %0d",
                 k, obs, RETIRED, t[k].exp, t[k].ret);
      end
    end
  endtask

  task automatic test_st();
    row_t t[$];
    t.push_back(mk(5, 1, 0, 1, pk(0,0,0,0,0,0,0,0,0,0), 0));
    t.push_back(mk(5, 1, 0, 0, pk(0,1,0,1,1,0,0,0,0,0), 0));
    t.push_back(mk(5, 1, 0, 0, pk(1,0,0,0,0,0,0,0,0,0), 0));
    t.push_back(mk(5, 1, 0, 0, pk(2,0,0,0,0,0,0,0,0,0), 0));
    t.push_back(mk(5, 1, 0, 0, pk(3,1,1,0,0,0,0,0,0,0), 0));
    t.push_back(mk(5, 0, 0, 0, pk(0,1,0,0,0,0,0,0,0,0), 1));
    foreach (t[k]) begin
      drive(t[k]);
      n_vec++;
      if (obs !== t[k].exp || RETIRED !== t[k].ret) begin
        n_bad++;
        $display("FAIL st row%0d: outs=%h retired=%0d, want %h / %0d",
                 k, obs, RETIRED, t[k].exp, t[k].ret);
      end
    end
  endtask

  task automatic test_alu_ops();
    row_t t[$];
    t.push_back(mk(1, 1, 0, 1, pk(0,0,0,0,0,0,0,0,0,0), 0));
    for (int op = 1; op <= 3; op++) begin
      t.push_back(mk(op, 1, 1, 0, pk(0,1,0,1,1,0,0,0,0,0), op - 1));
      t.push_back(mk(op, 1, 1, 0, pk(1,0,0,0,0,0,0,0,0,0), op - 1));
      t.push_back(mk(op, 1, 1, 0, pk(2,0,0,0,0,0,0,0,op,0), op - 1));
      t.push_back(mk(op, 1, 1, 0, pk(4,0,0,0,0,1,0,0,0,0), op - 1));
    end
    t.push_back(mk(0, 0, 0, 0, pk(0,1,0,0,0,0,0,0,0,0), 3));
    foreach (t[k]) begin
      drive(t[k]);
      n_vec++;
      if (obs !== t[k].exp || RETIRED !== t[k].ret) begin
        n_bad++;
        $display("FAIL alu_ops row%0d: outs=%h retired=%0d, want %h / %0d",
                 k, obs, RETIRED, t[k].exp, t[k].ret);
      end
    end
  endtask

  task automatic test_branch_jump();
    row_t t[$];
    t.push_back(mk(6, 1, 0, 1, pk(0,0,0,0,0,0,0,0,0,0), 0));
    // BEQ taken
    t.push_back(mk(6, 1, 1, 0, pk(0,1,0,1,1,0,0,0,0,0), 0));
    t.push_back(mk(6, 1, 1, 0, pk(1,0,0,0,0,0,0,0,0,0), 0));
    t.push_back(mk(6, 1, 1, 0, pk(2,0,0,0,1,0,1,0,1,0), 0));
    // BEQ not taken
    t.push_back(mk(6, 1, 0, 0, pk(0,1,0,1,1,0,0,0,0,0), 1));
    t.push_back(mk(6, 1, 0, 0, pk(1,0,0,0,0,0,0,0,0,0), 1));
    t.push_back(mk(6, 1, 0, 0, pk(2,0,0,0,0,0,0,0,1,0), 1));
    // JMP
    t.push_back(mk(7, 1, 0, 0, pk(0,1,0,1,1,0,0,0,0,0), 2));
    t.push_back(mk(7, 1, 0, 0, pk(1,0,0,0,1,0,2,0,0,0), 2));
    t.push_back(mk(7, 0, 0, 0, pk(0,1,0,0,0,0,0,0,0,0), 3));
    foreach (t[k]) begin
      drive(t[k]);
      n_vec++;
      if (obs !== t[k].exp || RETIRED !== t[k].ret) begin
        n_bad++;
        $display("FAIL branch_jump row%0d: outs=%h retired=%0d, want %h / %0d",
                 k, obs, RETIRED, t[k].exp, t[k].ret);
      end
    end
  endtask

  task automatic test_halt();
    row_t t[$];
    t.push_back(mk(15, 1, 0, 1, pk(0,0,0,0,0,0,0,0,0,0), 0));
    t.push_back(mk(15, 1, 0, 0, pk(0,1,0,1,1,0,0,0,0,0), 0));
    t.push_back(mk(15, 1, 0, 0, pk(1,0,0,0,0,0,0,0,0,0), 0));
    for (int i = 0; i < 10; i++)
      t.push_back(mk(i % 8, 1, 1, 0, pk(5,0,0,0,0,0,0,0,0,1), 1));
    t.push_back(mk(0, 1, 0, 1, pk(0,0,0,0,0,0,0,0,0,0), 0));
    t.push_back(mk(0, 0, 0, 0, pk(0,1,0,0,0,0,0,0,0,0), 0));
    foreach (t[k]) begin
      drive(t[k]);
      n_vec++;
      if (obs !== t[k].exp || RETIRED !== t[k].ret) begin
        n_bad++;
        $display("FAIL halt row%0d: outs=%h retired=%0d, want %h / %0d",
                 k, obs, RETIRED, t[k].exp, t[k].ret);
      end
    end
  endtask

  // 256 illegal-opcode NOPs: the 8-bit instance wraps 255 -> 0, the 16-bit one reaches 256.
  task automatic test_nop_wrap();
    logic [14:0] e_go, e_dec, e_wait;
    e_go   = pk(0,1,0,1,1,0,0,0,0,0);
    e_dec  = pk(1,0,0,0,0,0,0,0,0,0);
    e_wait = pk(0,1,0,0,0,0,0,0,0,0);
    drive(mk(8, 1, 0, 1, pk(0,0,0,0,0,0,0,0,0,0), 0));
    n_vec++;
    if (RETIRED !== 16'd0 || retired_w !== 8'd0) begin
      n_bad++;
      $display("FAIL nop_wrap reset: retired=%0d/%0d, want 0/0", RETIRED, retired_w);
    end
    for (int i = 0; i < 256; i++) begin
      drive(mk(8 + (i % 7), 1, 0, 0, e_go, i));
      n_vec++;
      if (obs !== e_go || obs_w !== e_go || RETIRED !== 16'(i) || retired_w !== 8'(i)) begin
        n_bad++;
        $display("FAIL nop_wrap fetch%0d: outs=%h/%h retired=%0d/%0d, want %h / %0d/%0d",
                 i, obs, obs_w, RETIRED, retired_w, e_go, i, i % 256);
      end
      drive(mk(8 + (i % 7), 1, 0, 0, e_dec, i));
      n_vec++;
      if (obs !== e_dec || obs_w !== e_dec) begin
        n_bad++;
        $display("FAIL nop_wrap decode%0d: outs=%h/%h, want %h", i, obs, obs_w, e_dec);
      end
    end
    drive(mk(0, 0, 0, 0, e_wait, 256));
    n_vec++;
    if (obs !== e_wait || RETIRED !== 16'd256 || retired_w !== 8'd0) begin
      n_bad++;
      $display("FAIL nop_wrap final: outs=%h retired=%0d/%0d, want %h / 256/0",
               obs, RETIRED, retired_w, e_wait);
    end
  endtask

  // Continues from the wrap test: reset lands while an LD sits in MEM with MEM_READY high.
  task automatic test_reset_in_mem();
    row_t t[$];
    t.push_back(mk(4, 1, 0, 0, pk(0,1,0,1,1,0,0,0,0,0), 256));
    t.push_back(mk(4, 1, 0, 0, pk(1,0,0,0,0,0,0,0,0,0), 256));
    t.push_back(mk(4, 1, 0, 0, pk(2,0,0,0,0,0,0,0,0,0), 256));
    t.push_back(mk(4, 0, 0, 0, pk(3,1,0,0,0,0,0,0,0,0), 256));
    t.push_back(mk(4, 1, 1, 1, pk(0,0,0,0,0,0,0,0,0,0), 0));
    t.push_back(mk(4, 0, 0, 0, pk(0,1,0,0,0,0,0,0,0,0), 0));
    foreach (t[k]) begin
      drive(t[k]);
      n_vec++;
      if (obs !== t[k].exp || RETIRED !== t[k].ret) begin
        n_bad++;
        $display("FAIL reset_in_mem row%0d: outs=%h retired=%0d, want %h / %0d",
                 k, obs, RETIRED, t[k].exp, t[k].ret);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_add();
    test_ld_waits();
    test_st();
    test_alu_ops();
    test_branch_jump();
    test_halt();
    test_nop_wrap();
    test_reset_in_mem();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
